// File: rtl/shift_pkg.sv
// Shared constants and next-state helper for the parallel-load shift register.
// The helper works on a wide vector so any register width up to MAX_W can use it.
package shift_pkg;

  localparam logic SHIFT_DIR_RIGHT = 1'b0;
  localparam logic SHIFT_DIR_LEFT  = 1'b1;
  localparam int   MAX_W           = 64;

  // Only the low `width` bits of q are meaningful; upper result bits are zero.
  function automatic logic [MAX_W-1:0] shift_next(
    input logic [MAX_W-1:0] q,
    input logic             dir,
    input logic             rotate,
    input int               width = 4
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] r;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    top  = (q & mask) >> (width - 1);
    if (dir == SHIFT_DIR_LEFT) begin
      r = ((q << 1) & mask) | MAX_W'(rotate & top[0]);
    end else begin
      r = ((q & mask) >> 1)
        | (MAX_W'(rotate & q[0]) << (width - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Parallel-load shift register: load has priority, otherwise shift every edge.
// Direction and zero-fill/rotate are fixed at elaboration.
module shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SHIFT_LEFT = 0,
  parameter int ROTATE     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("shift_register: WIDTH out of range");
  end
  if (SHIFT_LEFT != 0 && SHIFT_LEFT != 1) begin : g_bad_dir
    $error("shift_register: SHIFT_LEFT must be 0 or 1");
  end
  if (ROTATE != 0 && ROTATE != 1) begin : g_bad_rot
    $error("shift_register: ROTATE must be 0 or 1");
  end

  localparam logic DIR = (SHIFT_LEFT == 1) ? SHIFT_DIR_LEFT
                                           : SHIFT_DIR_RIGHT;
  localparam logic ROT = (ROTATE == 1);

  logic [WIDTH-1:0] q_nxt;

  assign q_nxt = WIDTH'(shift_next(MAX_W'(q), DIR, ROT, WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench: four configurations against an arithmetic model,
// plus hand-computed sequences for the main scenarios.
module tb_shift_register;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic l0 = 1'b0, l1 = 1'b0, l2 = 1'b0, l3 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0;
  logic [7:0] d3 = '0;
  logic [3:0] q0, q1, q2;
  logic [7:0] q3;

  int checks = 0;
  int errors = 0;
  int m[4];
  bit run_chk = 1'b0;

  localparam int W[4]  = '{4, 4, 4, 8};
  localparam bit LF[4] = '{0, 1, 0, 0};
  localparam bit RT[4] = '{0, 0, 1, 0};

  shift_register #(.WIDTH(4), .SHIFT_LEFT(0), .ROTATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .load(l0), .d(d0), .q(q0));
  shift_register #(.WIDTH(4), .SHIFT_LEFT(1), .ROTATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(l1), .d(d1), .q(q1));
  shift_register #(.WIDTH(4), .SHIFT_LEFT(0), .ROTATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .load(l2), .d(d2), .q(q2));
  shift_register #(.WIDTH(8), .SHIFT_LEFT(0), .ROTATE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .load(l3), .d(d3), .q(q3));

  always #5 clk = ~clk;

  function automatic logic [7:0] qv(int i);
    case (i)
      0: return {4'b0, q0};
      1: return {4'b0, q1};
      2: return {4'b0, q2};
      default: return q3;
    endcase
  endfunction

  function automatic bit getl(int i);
    case (i)
      0: return l0;
      1: return l1;
      2: return l2;
      default: return l3;
    endcase
  endfunction

  function automatic int getd(int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  // Model: shift as plain integer arithmetic on a w-bit value.
  function automatic int step(int v, int w, bit left, bit rot);
    int msk;
    msk = (1 << w) - 1;
    if (left)
      return ((v << 1) & msk) | (rot ? ((v >> (w - 1)) & 1) : 0);
    return (v >> 1) | (rot ? ((v & 1) << (w - 1)) : 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) m[i] = 0;
      else if (getl(i)) m[i] = getd(i) & ((1 << W[i]) - 1);
      else m[i] = step(m[i], W[i], LF[i], RT[i]);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv(i) !== m[i][7:0]) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t: q=%0h expected %0h",
                   i, $time, qv(i), m[i][7:0]);
        end
      end
    end
  end

  task automatic chk(string nm, int i, int exp);
    checks++;
    if (qv(i) !== exp[7:0]) begin
      errors++;
      $display("FAIL %s dut%0d: q=%0h expected %0h",
               nm, i, qv(i), exp[7:0]);
    end
  endtask

  task automatic setin(int i, bit ld, int v);
    case (i)
      0: begin l0 = ld; d0 = v[3:0]; end
      1: begin l1 = ld; d1 = v[3:0]; end
      2: begin l2 = ld; d2 = v[3:0]; end
      default: begin l3 = ld; d3 = v[7:0]; end
    endcase
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(int i, int v);
    setin(i, 1'b1, v);
    edge1();
    setin(i, 1'b0, $urandom);
  endtask

  task automatic all_idle();
    for (int i = 0; i < 4; i++) setin(i, 1'b0, 0);
  endtask

  initial begin
    // Reset held with clock toggling
    all_idle();
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("reset_hold", 0, 0);
    end
    #2 rst_n = 1'b1;
    run_chk = 1'b1;

    // Load and drain
    load_one(0, 'hA);
    chk("drain_a_load", 0, 'hA);
    edge1(); chk("drain_a_1", 0, 'h5);
    edge1(); chk("drain_a_2", 0, 'h2);
    edge1(); chk("drain_a_3", 0, 'h1);
    for (int k = 0; k < 3; k++) begin
      edge1(); chk("drain_a_zero", 0, 'h0);
    end

    // Reload, with X on d while not loading
    load_one(0, 'hF);
    d0 = 'x;
    chk("reload", 0, 'hF);
    edge1(); chk("reload_1", 0, 'h7);
    edge1(); chk("reload_2", 0, 'h3);
    edge1(); chk("reload_3", 0, 'h1);
    edge1(); chk("reload_4", 0, 'h0);
    d0 = '0;

    // Load priority over shift
    setin(0, 1'b1, 'hC); edge1(); chk("prio_c", 0, 'hC);
    setin(0, 1'b1, 'h3); edge1(); chk("prio_3", 0, 'h3);
    setin(0, 1'b1, 'h9); edge1(); chk("prio_9", 0, 'h9);
    setin(0, 1'b0, 0);   edge1(); chk("prio_shift", 0, 'h4);

    // Async reset mid-drain
    load_one(0, 'hF);
    edge1(); edge1();
    chk("mid_pre", 0, 'h3);
    #1 rst_n = 1'b0;
    #1 chk("mid_async", 0, 'h0);
    #1 rst_n = 1'b1;
    edge1(); chk("mid_after", 0, 'h0);

    // Left shift
    load_one(1, 'h5); chk("left_load", 1, 'h5);
    edge1(); chk("left_1", 1, 'hA);
    edge1(); chk("left_2", 1, 'h4);
    edge1(); chk("left_3", 1, 'h8);
    edge1(); chk("left_4", 1, 'h0);

    // Right rotate
    load_one(2, 'h1); chk("rot_load", 2, 'h1);
    edge1(); chk("rot_1", 2, 'h8);
    edge1(); chk("rot_2", 2, 'h4);
    edge1(); chk("rot_3", 2, 'h2);
    edge1(); chk("rot_4", 2, 'h1);

    // Eight-bit drain of MSB
    load_one(3, 'h80);
    for (int k = 1; k < 8; k++) edge1();
    chk("w8_seven", 3, 'h01);
    edge1(); chk("w8_eight", 3, 'h00);

    // Randomised traffic with occasional async reset pulses
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        setin(i, ($urandom_range(0, 3) == 0), int'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rand_async", n % 4, 0);
        #1 rst_n = 1'b1;
      end
      edge1();
    end

    all_idle();
    edge1();
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
